core_encode_data: RTL and testbench
===================================

CORE_ENCODE_DATA -- requirements
Module: core_encode_data

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 in_valid / in_ready  in / out  1 / 1  request handshake; a request is accepted when both are high.
REQ-004 in_cond  in  4  condition field, copied to insn[31:28].
REQ-005 in_op  in  4  ALU opcode: AND=0, EOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=A, CMN=B, ORR=C, MOV=D, BIC=E, MVN=F.
REQ-006 in_rn, in_rd  in  4 each  register numbers.
REQ-007 in_s, in_restore_spsr  in  1 each  update-flags request; SPSR-restore request.
REQ-008 in_imm  in  1  1 = immediate second operand taken from in_value; 0 = register second operand.
REQ-009 in_value  in  32  immediate constant to encode.
REQ-010 in_rm, in_shift_type, in_shift_imm  in  4, 2, 5  register operand, shift type, shift amount.
REQ-011 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 out_insn  out  32  encoded data-processing instruction.
REQ-013 out_error  out  1  immediate not encodable; out_insn is 0 when set.

Function
REQ-014 States: IDLE, SCAN, ALT_SCAN, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 All request inputs SHALL be registered on acceptance; later changes to the inputs SHALL have no effect on the request.
REQ-016 Encoding: insn[27:26]=00, [25]=I, [24:21]=op, [20]=S, [19:16]=Rn, [15:12]=Rd, [11:0]=operand2.
REQ-017 Register mode (in_imm=0): operand2 = {shift_imm[4:0], shift_type[1:0], 1'b0, rm}; the FSM SHALL go IDLE->DONE, so out_valid is high at T+1 for acceptance cycle T.
REQ-018 Immediate mode: the FSM SHALL go IDLE->SCAN with rotation counter r=0.
REQ-019 In SCAN, the block SHALL test one rotation per cycle: the test passes when bits [31:8] of (value ROL 2r) are 0.
REQ-020 On a pass at rotation r, operand2 SHALL be {r[3:0], (value ROL 2r)[7:0]} and the FSM SHALL go to DONE; rotations are tested in order 0..15, so the smallest passing r is used.
REQ-021 Timing: rotation r is tested in cycle T+1+r; a pass gives out_valid at T+2+r.
REQ-022 If r=15 fails and the op has an alternate, the FSM SHALL enter ALT_SCAN with r=0, substituting the alternate op and value.
REQ-023 Alternates: MOV<->MVN and AND<->BIC and ADC<->SBC use ~value; ADD<->SUB and CMP<->CMN use -value (two's complement, modulo 2^32); all other ops have no alternate.
REQ-024 ALT_SCAN timing: rotation r is tested in cycle T+17+r; a pass gives out_valid at T+18+r.
REQ-025 Failure: r=15 fails with no alternate, or ALT_SCAN r=15 fails -> DONE with out_error=1 and out_insn=0 (out_valid at T+17 or T+33).
REQ-026 Compare ops (TST/TEQ/CMP/CMN): S SHALL be 1, Rd field 0000, and in_restore_spsr is ignored.
REQ-027 MOV/MVN: the Rn field SHALL be 0000.
REQ-028 Other ops: S = in_s | in_restore_spsr; when in_restore_spsr=1, the Rd field SHALL be 1111 regardless of in_rd.
REQ-029 In DONE, out_insn and out_error SHALL hold stable while out_ready=0.
REQ-030 The DONE->IDLE transition SHALL occur on out_valid & out_ready; in_ready rises the next cycle (no same-cycle accept).

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, r=0, out_valid=0, out_insn=0, out_error=0, in_ready=1.
REQ-032 A reset in SCAN, ALT_SCAN or DONE SHALL discard the request; no out_valid pulse for it SHALL appear after reset release.

Verification
REQ-033 ADD r1,r2,#0xFF, cond=E, imm -> out_valid at T+2, out_insn=0xE28210FF, out_error=0.
REQ-034 MOV r0,#0xFF000000 -> r=4 passes; out_valid at T+6, out_insn=0xE3A004FF.
REQ-035 MOV r0,#0xFFFFFF00 -> primary scan fails, alternate MVN #0xFF passes; out_valid at T+18, out_insn=0xE3E000FF.
REQ-036 ADD r0,r0,#0x101 -> both scans fail; out_valid at T+33, out_error=1, out_insn=0.
REQ-037 Register SUB, rn=14, rd=3, rm=0, restore_spsr=1, s=0 -> out_valid at T+1, out_insn=0xE05EF000.
REQ-038 Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0; then pulse rst_n low mid-SCAN: out_valid=0, in_ready=1 immediately, no stale result afterwards.

Source files
------------

// File: rtl/core_encode_data.sv
// core_encode_data: encodes a data-processing instruction (ARM-style) from a
// request. A register second operand is encoded in one cycle. An immediate
// second operand is searched over rotations 0..15, one per cycle. If no
// rotation fits, the search is repeated with an alternate opcode (complement
// or negated value) when the opcode has one. If the value still cannot be
// encoded, the result is flagged as an error.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (in_ready high only in IDLE)
//   in_cond, in_op          condition field, ALU opcode
//   in_rn, in_rd            register numbers
//   in_s, in_restore_spsr   flag-update request, SPSR-restore request
//   in_imm, in_value        immediate-mode select, immediate constant
//   in_rm, in_shift_type,
//   in_shift_imm            register-mode operand and shift
//   out_valid / out_ready   result handshake (out_valid high only in DONE)
//   out_insn, out_error     encoded instruction; error (out_insn = 0 when set)
module core_encode_data (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic        in_s,
  input  logic        in_restore_spsr,
  input  logic        in_imm,
  input  logic [31:0] in_value,
  input  logic [3:0]  in_rm,
  input  logic [1:0]  in_shift_type,
  input  logic [4:0]  in_shift_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_error
);

  typedef enum logic [1:0] {IDLE, SCAN, ALT_SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  r_q, r_d;

  logic [3:0]  cond_q, op_q, rn_q, rd_q;
  logic        s_q, restore_q;
  logic [31:0] value_q;

  logic        accept, finish_ok, finish_err, go_alt;
  logic        has_alt;
  logic [3:0]  alt_op;
  logic [31:0] alt_value;
  logic [63:0] rot_wide;
  logic [31:0] rotated;
  logic        pass;

  // Compare ops always set S and have no destination; MOV/MVN have no Rn.
  // SPSR restore forces S and Rd=PC on every non-compare op.
  function automatic logic [31:0] build_insn(
    input logic [3:0]  cond,
    input logic [3:0]  op,
    input logic        i,
    input logic        s,
    input logic        restore,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] op2
  );
    logic       cmp_op, mov_op, s_bit;
    logic [3:0] rn_f, rd_f;
    cmp_op = (op[3:2] == 2'b10);
    mov_op = (op == 4'hD) || (op == 4'hF);
    s_bit  = cmp_op ? 1'b1 : (s | restore);
    rd_f   = cmp_op ? 4'h0 : (restore ? 4'hF : rd);
    rn_f   = mov_op ? 4'h0 : rn;
    return {cond, 2'b00, i, op, s_bit, rn_f, rd_f, op2};
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // value ROL 2r is the upper half of the doubled word shifted left.
  assign rot_wide = {value_q, value_q} << {r_q, 1'b0};
  assign rotated  = rot_wide[63:32];
  assign pass     = (rotated[31:8] == 24'd0);

  always_comb begin
    has_alt   = 1'b1;
    alt_op    = op_q;
    alt_value = ~value_q;
    case (op_q)
      4'hD: alt_op = 4'hF;
      4'hF: alt_op = 4'hD;
      4'h0: alt_op = 4'hE;
      4'hE: alt_op = 4'h0;
      4'h5: alt_op = 4'h6;
      4'h6: alt_op = 4'h5;
      4'h4: begin alt_op = 4'h2; alt_value = -value_q; end
      4'h2: begin alt_op = 4'h4; alt_value = -value_q; end
      4'hA: begin alt_op = 4'hB; alt_value = -value_q; end
      4'hB: begin alt_op = 4'hA; alt_value = -value_q; end
      default: has_alt = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    accept     = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    go_alt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          r_d     = 4'd0;
          state_d = in_imm ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (pass) begin
          finish_ok = 1'b1;
          state_d   = DONE;
        end else if (r_q == 4'd15) begin
          r_d = 4'd0;
          if (has_alt) begin
            go_alt  = 1'b1;
            state_d = ALT_SCAN;
          end else begin
            finish_err = 1'b1;
            state_d    = DONE;
          end
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      ALT_SCAN: begin
        if (pass) begin
          finish_ok = 1'b1;
          state_d   = DONE;
        end else if (r_q == 4'd15) begin
          finish_err = 1'b1;
          state_d    = DONE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q    <= '0;
      op_q      <= '0;
      rn_q      <= '0;
      rd_q      <= '0;
      s_q       <= 1'b0;
      restore_q <= 1'b0;
      value_q   <= '0;
      out_insn  <= '0;
      out_error <= 1'b0;
    end else begin
      if (accept) begin
        cond_q    <= in_cond;
        op_q      <= in_op;
        rn_q      <= in_rn;
        rd_q      <= in_rd;
        s_q       <= in_s;
        restore_q <= in_restore_spsr;
        value_q   <= in_value;
        // Register mode is finished in the accept cycle, straight from inputs.
        if (!in_imm) begin
          out_insn  <= build_insn(in_cond, in_op, 1'b0, in_s, in_restore_spsr,
                                  in_rn, in_rd,
                                  {in_shift_imm, in_shift_type, 1'b0, in_rm});
          out_error <= 1'b0;
        end
      end
      if (go_alt) begin
        op_q    <= alt_op;
        value_q <= alt_value;
      end
      if (finish_ok) begin
        out_insn  <= build_insn(cond_q, op_q, 1'b1, s_q, restore_q, rn_q, rd_q,
                                {r_q, rotated[7:0]});
        out_error <= 1'b0;
      end
      if (finish_err) begin
        out_insn  <= '0;
        out_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_encode_data.sv
module tb_core_encode_data;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond, in_op, in_rn, in_rd;
  logic        in_s, in_restore_spsr, in_imm;
  logic [31:0] in_value;
  logic [3:0]  in_rm;
  logic [1:0]  in_shift_type;
  logic [4:0]  in_shift_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_error;

  int checks = 0;
  int failures = 0;

  core_encode_data dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_op(in_op), .in_rn(in_rn), .in_rd(in_rd),
    .in_s(in_s), .in_restore_spsr(in_restore_spsr), .in_imm(in_imm),
    .in_value(in_value), .in_rm(in_rm), .in_shift_type(in_shift_type),
    .in_shift_imm(in_shift_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_error(out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cond, op, rn, rd;
    logic        s, restore, imm;
    logic [31:0] value;
    logic [3:0]  rm;
    logic [1:0]  st;
    logic [4:0]  sh;
    logic [31:0] exp_insn;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] cond, op, rn, rd,
                     input logic s, restore, imm, input logic [31:0] value,
                     input logic [3:0] rm, input logic [1:0] st, input logic [4:0] sh,
                     input logic [31:0] exp_insn, input logic exp_err, input int exp_lat);
    vec_t v;
    v.name = name; v.cond = cond; v.op = op; v.rn = rn; v.rd = rd;
    v.s = s; v.restore = restore; v.imm = imm; v.value = value;
    v.rm = rm; v.st = st; v.sh = sh;
    v.exp_insn = exp_insn; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  task automatic scramble();
    in_cond = 4'($urandom); in_op = 4'($urandom); in_rn = 4'($urandom);
    in_rd = 4'($urandom); in_s = 1'($urandom); in_restore_spsr = 1'($urandom);
    in_imm = 1'($urandom); in_value = $urandom; in_rm = 4'($urandom);
    in_shift_type = 2'($urandom); in_shift_imm = 5'($urandom);
  endtask

  // Drives one request; returns after the accepting edge (+1 time unit).
  task automatic send(input vec_t v);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (!in_ready) check({v.name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    in_cond = v.cond; in_op = v.op; in_rn = v.rn; in_rd = v.rd;
    in_s = v.s; in_restore_spsr = v.restore; in_imm = v.imm;
    in_value = v.value; in_rm = v.rm; in_shift_type = v.st; in_shift_imm = v.sh;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Counts cycles after acceptance until out_valid; bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held_insn;
    logic        held_err;
    int          stale;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    scramble();

    //   name        cond  op    rn    rd   s  rs imm value          rm    st  sh   insn          err lat
    add("add_ff",   4'hE, 4'h4, 4'd2, 4'd1, 0, 0, 1, 32'h000000FF, 4'd0, 0, 0, 32'hE28210FF, 0, 2);
    add("mov_rot4", 4'hE, 4'hD, 4'd9, 4'd0, 0, 0, 1, 32'hFF000000, 4'd0, 0, 0, 32'hE3A004FF, 0, 6);
    add("mov_alt",  4'hE, 4'hD, 4'd0, 4'd0, 0, 0, 1, 32'hFFFFFF00, 4'd0, 0, 0, 32'hE3E000FF, 0, 18);
    add("add_err",  4'hE, 4'h4, 4'd0, 4'd0, 0, 0, 1, 32'h00000101, 4'd0, 0, 0, 32'h00000000, 1, 33);
    add("sub_reg",  4'hE, 4'h2, 4'd14,4'd3, 0, 1, 0, 32'h00000000, 4'd0, 0, 0, 32'hE05EF000, 0, 1);
    add("tst_r15",  4'h0, 4'h8, 4'd3, 4'd7, 0, 1, 1, 32'h000003FC, 4'd0, 0, 0, 32'h03130FFF, 0, 17);
    add("cmp_neg",  4'hE, 4'hA, 4'd1, 4'd5, 0, 0, 1, 32'hFFFFFFFF, 4'd0, 0, 0, 32'hE3710001, 0, 18);
    add("orr_noalt",4'hE, 4'hC, 4'd2, 4'd3, 1, 0, 1, 32'h00000101, 4'd0, 0, 0, 32'h00000000, 1, 17);
    add("eor_reg",  4'h1, 4'h1, 4'd4, 4'd5, 1, 0, 0, 32'hFFFFFFFF, 4'd7, 2, 3, 32'h103451C7, 0, 1);
    add("and_bic",  4'hE, 4'h0, 4'd2, 4'd1, 0, 0, 1, 32'hFFFFFF00, 4'd0, 0, 0, 32'hE3C210FF, 0, 18);

    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_insn", out_insn, 32'd0);
    check("reset_out_error", 32'(out_error), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_valid(lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_insn"}, out_insn, vecs[i].exp_insn);
      check({vecs[i].name, "_err"}, 32'(out_error), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check({vecs[i].name, "_idle"}, 32'(in_ready & ~out_valid), 32'd1);
    end

    // Back-pressure: result must hold in DONE while out_ready is low.
    out_ready = 1'b0;
    send(vecs[1]);
    wait_valid(lat);
    check("hold_lat", 32'(lat), 32'd6);
    held_insn = out_insn;
    held_err  = out_error;
    check("hold_insn0", held_insn, 32'hE3A004FF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_insn", out_insn, 32'hE3A004FF);
      check("hold_err", 32'(out_error), 32'(held_err));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_idle", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a scan discards the request.
    send(vecs[3]);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_ready", 32'(in_ready), 32'd1);
    check("midreset_insn", out_insn, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);
    check("post_reset_ready", 32'(in_ready), 32'd1);

    // Still functional after the reset.
    send(vecs[0]);
    wait_valid(lat);
    check("post_reset_lat", 32'(lat), 32'd2);
    check("post_reset_insn", out_insn, 32'hE28210FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
